// File: rtl/wbc_master_arbiter_if.sv
// Bus bundle between the bus masters, the arbiter and the shared WISHBONE
// classic slave port. The slave modport is the arbiter's view: it receives
// master requests and slave terminations, and drives the slave-side request
// and the routed terminations. The master modport is the surrounding system.
interface wbc_master_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADR_WIDTH   = 22,
    parameter int DAT_WIDTH   = 32
);
    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS*ADR_WIDTH-1:0]     m_adr_i;
    logic [NUM_MASTERS*DAT_WIDTH-1:0]     m_dat_i;
    logic [NUM_MASTERS*DAT_WIDTH/8-1:0]   m_sel_i;
    logic [DAT_WIDTH-1:0]                 m_dat_o;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic [NUM_MASTERS-1:0]               m_rty_o;
    logic                                 s_cyc_o;
    logic                                 s_stb_o;
    logic                                 s_we_o;
    logic [ADR_WIDTH-1:0]                 s_adr_o;
    logic [DAT_WIDTH-1:0]                 s_dat_o;
    logic [DAT_WIDTH/8-1:0]               s_sel_o;
    logic [DAT_WIDTH-1:0]                 s_dat_i;
    logic                                 s_ack_i;
    logic                                 s_err_i;
    logic                                 s_rty_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wbc_master_arbiter.sv
// Round-robin arbiter sharing one WISHBONE classic slave port between
// NUM_MASTERS masters. A tenure lasts while the owner holds cyc; the owner's
// request is muxed straight onto the slave side and terminations are routed
// back to the owner only. A stb left unterminated for TIMEOUT cycles is ended
// with a forced err, and any late termination is swallowed until the owner
// drops stb.
module wbc_master_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADR_WIDTH   = 22,
    parameter int DAT_WIDTH   = 32,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wbc_master_arbiter_if.slave    bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);
    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_MASTERS - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                 state_r, state_n;
    logic [NUM_MASTERS-1:0] grant_r, grant_n;
    logic [IDX_WIDTH-1:0]   owner_r, owner_n;
    logic [IDX_WIDTH-1:0]   ptr_r, ptr_n;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_n;
    logic                   discard_r, discard_n;

    logic                   own_cyc_s, own_stb_s, own_we_s;
    logic [ADR_WIDTH-1:0]   own_adr_s;
    logic [DAT_WIDTH-1:0]   own_dat_s;
    logic [SEL_WIDTH-1:0]   own_sel_s;
    logic [NUM_MASTERS-1:0] owner_bit_s;
    logic                   term_s, live_s, timeout_s;

    // First requester at or after the pointer, wrapping past the last master.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [IDX_WIDTH-1:0]   ptr);
        logic [IDX_WIDTH-1:0] sel;
        logic                 found;
        int                   idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                sel   = IDX_WIDTH'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    assign owner_bit_s = ONE_HOT_0 << owner_r;
    assign grant_o     = grant_r;
    assign timeout_o   = timeout_s;

    // AND-OR select of the current owner's request signals.
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        own_we_s  = 1'b0;
        own_adr_s = '0;
        own_dat_s = '0;
        own_sel_s = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            own_cyc_s = own_cyc_s | (owner_bit_s[k] & bus.m_cyc_i[k]);
            own_stb_s = own_stb_s | (owner_bit_s[k] & bus.m_stb_i[k]);
            own_we_s  = own_we_s  | (owner_bit_s[k] & bus.m_we_i[k]);
            own_adr_s = own_adr_s | ({ADR_WIDTH{owner_bit_s[k]}} & bus.m_adr_i[k*ADR_WIDTH +: ADR_WIDTH]);
            own_dat_s = own_dat_s | ({DAT_WIDTH{owner_bit_s[k]}} & bus.m_dat_i[k*DAT_WIDTH +: DAT_WIDTH]);
            own_sel_s = own_sel_s | ({SEL_WIDTH{owner_bit_s[k]}} & bus.m_sel_i[k*SEL_WIDTH +: SEL_WIDTH]);
        end
    end

    // Tenure FSM next state plus slave-side drive, termination routing and timeout.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        owner_n     = owner_r;
        ptr_n       = ptr_r;
        cnt_n       = '0;
        discard_n   = discard_r;
        term_s      = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
        live_s      = 1'b0;
        timeout_s   = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        case (state_r)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_n = OWN;
                    owner_n = rr_pick(bus.m_cyc_i, ptr_r);
                    grant_n = ONE_HOT_0 << owner_n;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                live_s      = own_stb_s & ~discard_r;
                timeout_s   = live_s & ~term_s & (cnt_r == CNT_LIMIT);
                bus.s_cyc_o = own_cyc_s & ~discard_r & ~timeout_s;
                bus.s_stb_o = live_s & ~timeout_s;
                bus.s_we_o  = own_we_s;
                bus.s_adr_o = own_adr_s;
                bus.s_dat_o = own_dat_s;
                bus.s_sel_o = own_sel_s;
                bus.m_dat_o = bus.s_dat_i;
                // A timeout only fires with no termination present, so a real ack always wins.
                if (timeout_s) begin
                    bus.m_err_o = owner_bit_s;
                end else if (!discard_r) begin
                    bus.m_ack_o = bus.s_ack_i ? owner_bit_s : '0;
                    bus.m_err_o = bus.s_err_i ? owner_bit_s : '0;
                    bus.m_rty_o = bus.s_rty_i ? owner_bit_s : '0;
                end else begin
                    bus.m_ack_o = '0;
                end
                if (live_s && !term_s && !timeout_s) begin
                    cnt_n = cnt_r + CNT_WIDTH'(1);
                end else begin
                    cnt_n = '0;
                end
                if (timeout_s) begin
                    discard_n = 1'b1;
                end else if (!own_stb_s) begin
                    discard_n = 1'b0;
                end else begin
                    discard_n = discard_r;
                end
                if (!own_cyc_s) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    ptr_n     = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_WIDTH'(1);
                    cnt_n     = '0;
                    discard_n = 1'b0;
                end else begin
                    state_n = OWN;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State, grant, pointer and timeout bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            owner_r   <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            grant_r   <= grant_n;
            owner_r   <= owner_n;
            ptr_r     <= ptr_n;
            cnt_r     <= cnt_n;
            discard_r <= discard_n;
        end
    end
endmodule

// File: tb/tb_wbc_master_arbiter.sv
// Bench for wbc_master_arbiter: directed scenarios plus a randomized run, all
// compared cycle by cycle against a small behavioural model of the arbiter.
module tb_wbc_master_arbiter;
    localparam int N  = 3;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    localparam int OW = N + 4 + AW + DW + SW + 3 * N + DW;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] grant;
    logic         timeout;

    wbc_master_arbiter_if #(.NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

    wbc_master_arbiter #(
        .NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus.slave),
        .grant_o  (grant),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Behavioural model: who owns the bus, where the rotation starts, how long
    // the current stb has waited, and whether late terminations are muted.
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_wait  = 0;
    bit mdl_mute  = 1'b0;

    logic [OW-1:0] last_obs, last_exp;
    logic [N-1:0]  last_grant, last_mack, last_merr, last_mrty, exp_ack;
    logic          last_timeout, last_sstb, last_scyc;
    logic [AW-1:0] last_sadr;

    task automatic clear_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_dat_i = DW'($urandom);
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
    endtask

    task automatic drive_master(input int i, input logic c, input logic s, input logic w,
                                input logic [AW-1:0] a);
        bus.m_cyc_i[i]             = c;
        bus.m_stb_i[i]             = s;
        bus.m_we_i[i]              = w;
        bus.m_adr_i[i*AW +: AW]    = a;
        bus.m_dat_i[i*DW +: DW]    = DW'($urandom);
        bus.m_sel_i[i*SW +: SW]    = SW'($urandom);
    endtask

    task automatic model_expect();
        logic [N-1:0]  g, ack, err, rty;
        logic          tov, sc, ss, sw;
        logic [AW-1:0] a;
        logic [DW-1:0] d, md;
        logic [SW-1:0] s;
        bit            term, live;
        int            o;
        g = '0; ack = '0; err = '0; rty = '0;
        tov = 1'b0; sc = 1'b0; ss = 1'b0; sw = 1'b0;
        a = '0; d = '0; md = '0; s = '0;
        if (mdl_owner >= 0) begin
            o    = mdl_owner;
            g    = N'(1) << o;
            term = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
            live = bus.m_stb_i[o] && !mdl_mute;
            tov  = live && !term && (mdl_wait == TO - 1);
            sc   = bus.m_cyc_i[o] && !mdl_mute && !tov;
            ss   = live && !tov;
            sw   = bus.m_we_i[o];
            a    = bus.m_adr_i[o*AW +: AW];
            d    = bus.m_dat_i[o*DW +: DW];
            s    = bus.m_sel_i[o*SW +: SW];
            md   = bus.s_dat_i;
            if (!mdl_mute) begin
                ack = bus.s_ack_i ? g : '0;
                err = bus.s_err_i ? g : '0;
                rty = bus.s_rty_i ? g : '0;
            end
            if (tov) err = g;
        end
        last_exp = {g, tov, sc, ss, sw, a, d, s, ack, err, rty, md};
        exp_ack  = ack;
    endtask

    task automatic model_advance();
        bit term, live, tov;
        int o, idx;
        if (rst) begin
            mdl_owner = -1; mdl_ptr = 0; mdl_wait = 0; mdl_mute = 1'b0;
        end else if (mdl_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                idx = (mdl_ptr + i) % N;
                if (mdl_owner < 0 && bus.m_cyc_i[idx]) mdl_owner = idx;
            end
        end else begin
            o    = mdl_owner;
            term = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
            live = bus.m_stb_i[o] && !mdl_mute;
            tov  = live && !term && (mdl_wait == TO - 1);
            if (!bus.m_cyc_i[o]) begin
                mdl_ptr = (o + 1) % N; mdl_owner = -1; mdl_wait = 0; mdl_mute = 1'b0;
            end else begin
                mdl_wait = (live && !term && !tov) ? mdl_wait + 1 : 0;
                if (tov) mdl_mute = 1'b1;
                else if (!bus.m_stb_i[o]) mdl_mute = 1'b0;
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs are sampled at the negedge, then the edge is modelled.
    task automatic step();
        #4;
        model_expect();
        last_obs = {grant, timeout, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
                    bus.s_dat_o, bus.s_sel_o, bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.m_dat_o};
        last_grant   = grant;
        last_timeout = timeout;
        last_sstb    = bus.s_stb_o;
        last_scyc    = bus.s_cyc_o;
        last_sadr    = bus.s_adr_o;
        last_mack    = bus.m_ack_o;
        last_merr    = bus.m_err_o;
        last_mrty    = bus.m_rty_o;
        @(posedge clk);
        model_advance();
        #1;
        cyc_no++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            bus.m_cyc_i = N'($urandom);
            bus.m_stb_i = bus.m_cyc_i;
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
        end
        checks++;
        if (last_grant !== 3'b000 || last_scyc !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant got=%b/%b want=000/0", last_grant, last_scyc);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        logic [AW-1:0] adr;
        reset_dut();
        adr = AW'($urandom);
        drive_master(1, 1'b1, 1'b1, 1'b1, adr);
        for (int k = 0; k < 4; k++) begin
            bus.s_ack_i = (k == 1);
            if (k == 2) drive_master(1, 1'b0, 1'b0, 1'b0, adr);
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL single_write cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
            if (k == 1) begin
                checks++;
                if (last_grant !== 3'b010 || last_sadr !== adr || last_mack !== 3'b010) begin
                    failures++;
                    $display("FAIL single_write_owner got grant=%b adr=%h ack=%b want 010 %h 010",
                             last_grant, last_sadr, last_mack, adr);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq[$];
        logic [N-1:0] prev;
        logic [N-1:0] want;
        bit           rel, gap_bad;
        reset_dut();
        prev = '0; gap_bad = 1'b0;
        bus.s_ack_i = 1'b1;
        for (int k = 0; k < 30 && seq.size() < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                rel = (mdl_owner == i) && exp_ack[i];
                drive_master(i, !rel, !rel, 1'b1, AW'($urandom));
            end
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL round_robin cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
            if (last_grant != '0 && last_grant != prev) begin
                seq.push_back(last_grant);
                if (prev != '0) gap_bad = 1'b1;
            end
            prev = last_grant;
        end
        checks++;
        if (seq.size() < 4) begin
            failures++;
            $display("FAIL round_robin_count got=%0d tenures want=4", seq.size());
        end else begin
            for (int t = 0; t < 4; t++) begin
                want = N'(1) << (t % N);
                checks++;
                if (seq[t] !== want) begin
                    failures++;
                    $display("FAIL round_robin_order tenure=%0d got=%b want=%b", t, seq[t], want);
                end
            end
        end
        checks++;
        if (gap_bad) begin
            failures++;
            $display("FAIL round_robin_gap got=no idle cycle want=idle between tenures");
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        reset_dut();
        drive_master(2, 1'b1, 1'b1, 1'b0, AW'($urandom));
        step();
        drive_master(0, 1'b1, 1'b1, 1'b1, AW'($urandom));
        for (int k = 0; k < 7; k++) begin
            bus.s_ack_i = (k < 4);
            if (k < 4) drive_master(2, 1'b1, 1'b1, 1'b0, AW'($urandom));
            if (k == 4) drive_master(2, 1'b0, 1'b0, 1'b0, AW'(0));
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL back_to_back cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
            if (k < 4) begin
                checks++;
                if (last_grant !== 3'b100 || last_mack !== 3'b100) begin
                    failures++;
                    $display("FAIL back_to_back_lock beat=%0d got grant=%b ack=%b want 100 100",
                             k, last_grant, last_mack);
                end
            end
        end
        checks++;
        if (last_grant !== 3'b001) begin
            failures++;
            $display("FAIL back_to_back_next got=%b want=001", last_grant);
        end
        clear_inputs();
    endtask

    task automatic check_vec(input string name);
        checks++;
        if (last_obs !== last_exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_no, last_obs, last_exp);
        end
    endtask

    task automatic test_timeout();
        int hit;
        reset_dut();
        drive_master(1, 1'b1, 1'b1, 1'b0, AW'($urandom));
        step();
        hit = -1;
        for (int k = 0; k < 40 && hit < 0; k++) begin
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL timeout_wait cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
            if (last_timeout === 1'b1) hit = k;
        end
        checks++;
        if (hit != TO - 1 || last_sstb !== 1'b0 || last_merr !== 3'b010) begin
            failures++;
            $display("FAIL timeout_pulse got at=%0d stb=%b err=%b want at=%0d stb=0 err=010",
                     hit, last_sstb, last_merr, TO - 1);
        end
        // Late ack while owner still holds stb must be swallowed.
        bus.s_ack_i = 1'b1;
        step();
        checks++;
        if (last_mack !== 3'b000 || last_sstb !== 1'b0 || last_obs !== last_exp) begin
            failures++;
            $display("FAIL timeout_late_ack got ack=%b stb=%b want ack=000 stb=0", last_mack, last_sstb);
        end
        bus.s_ack_i = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        step();
        bus.m_stb_i[1] = 1'b1;
        bus.s_ack_i = 1'b1;
        step();
        checks++;
        if (last_mack !== 3'b010 || last_obs !== last_exp) begin
            failures++;
            $display("FAIL timeout_restart got ack=%b want=010", last_mack);
        end
        // Ack on the very cycle the limit is reached wins over the timeout.
        for (int k = 0; k < TO; k++) begin
            bus.s_ack_i = (k == TO - 1);
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL timeout_ack_wins cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
        end
        checks++;
        if (last_timeout !== 1'b0 || last_mack !== 3'b010 || last_merr !== 3'b000) begin
            failures++;
            $display("FAIL timeout_ack_wins_final got to=%b ack=%b err=%b want 0 010 000",
                     last_timeout, last_mack, last_merr);
        end
        clear_inputs();
        step();
        check_vec("timeout_release");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        drive_master(1, 1'b1, 1'b1, 1'b1, AW'($urandom));
        bus.s_ack_i = 1'b1;
        step();
        step();
        check_vec("reset_mid_m1");
        clear_inputs();
        step();
        drive_master(2, 1'b1, 1'b1, 1'b0, AW'($urandom));
        step();
        step();
        check_vec("reset_mid_read");
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive_master(i, 1'b1, 1'b1, 1'b0, AW'($urandom));
        step();
        checks++;
        if (last_grant !== 3'b000 || last_scyc !== 1'b0 || last_mack !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_drop got grant=%b cyc=%b ack=%b want 000 0 000",
                     last_grant, last_scyc, last_mack);
        end
        step();
        checks++;
        if (last_grant !== 3'b001) begin
            failures++;
            $display("FAIL reset_mid_pointer got=%b want=001", last_grant);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_err_rty();
        reset_dut();
        drive_master(0, 1'b1, 1'b1, 1'b1, AW'($urandom));
        drive_master(1, 1'b1, 1'b1, 1'b1, AW'($urandom));
        step();
        bus.s_err_i = 1'b1;
        step();
        checks++;
        if (last_merr !== 3'b001 || last_mack !== 3'b000 || last_obs !== last_exp) begin
            failures++;
            $display("FAIL slave_err got err=%b ack=%b want err=001 ack=000", last_merr, last_mack);
        end
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b1;
        step();
        checks++;
        if (last_mrty !== 3'b001 || last_merr !== 3'b000 || last_obs !== last_exp) begin
            failures++;
            $display("FAIL slave_rty got rty=%b err=%b want rty=001 err=000", last_mrty, last_merr);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        bit silent;
        logic [N-1:0] c;
        reset_dut();
        c = '0;
        for (int k = 0; k < 700; k++) begin
            silent = ((k / 120) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, silent ? 39 : 5) == 0) c[i] = ~c[i];
                drive_master(i, c[i], c[i] & (silent || ($urandom_range(0, 2) != 0)),
                             1'($urandom), AW'($urandom));
            end
            bus.s_dat_i = DW'($urandom);
            bus.s_ack_i = !silent && ($urandom_range(0, 3) == 0);
            bus.s_err_i = !silent && ($urandom_range(0, 15) == 0);
            bus.s_rty_i = !silent && ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
            checks++;
            if (last_obs !== last_exp) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h want=%h", cyc_no, last_obs, last_exp);
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_err_rty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
